// File: rtl/rm380z_pkg.sv
// Shared definitions for the RM380Z ROM arbiter: FSM encoding, owner flag and
// the default CPU starvation limit.
package rm380z_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t StIdle = 2'd0;
   localparam arb_state_t StAddr = 2'd1;
   localparam arb_state_t StData = 2'd2;
   localparam arb_state_t StAck  = 2'd3;

   typedef enum logic {
      OwnerVid = 1'b0,
      OwnerCpu = 1'b1
   } owner_e;

   localparam int unsigned StarveLimitDefault = 3;

endpackage

// File: rtl/rom_arbiter.sv
// Shares one single-port, 1-cycle-latency ROM between the video fetch and the CPU.
// Video has priority except when the CPU has waited STARVE_LIMIT consecutive grants.
module rom_arbiter
   import rm380z_pkg::*;
#(
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned STARVE_LIMIT = StarveLimitDefault,
   localparam int unsigned AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [7:0]    vid_data,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   output logic          cpu_ack,
   output logic [7:0]    cpu_data,
   output logic [AW-1:0] rom_addr,
   input  logic [7:0]    rom_data,
   output logic          busy
);

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   arb_state_t    state_q, state_d;
   owner_e        owner_q, owner_d;
   logic [3:0]    starve_q, starve_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    vid_data_q, vid_data_d;
   logic [7:0]    cpu_data_q, cpu_data_d;
   logic          vid_ack_q, vid_ack_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          busy_q, busy_d;
   logic          grant_cpu;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      starve_d   = starve_q;
      addr_d     = addr_q;
      vid_data_d = vid_data_q;
      cpu_data_d = cpu_data_q;
      vid_ack_d  = 1'b0;
      cpu_ack_d  = 1'b0;
      grant_cpu  = 1'b0;

      case (state_q)
         StIdle: begin
            if (vid_req || cpu_req) begin
               grant_cpu = cpu_req && (!vid_req || (starve_q == StarveMax));
               state_d   = StAddr;
               owner_d   = grant_cpu ? OwnerCpu : OwnerVid;
               addr_d    = grant_cpu ? cpu_addr : vid_addr;
               // Count only video grants that made a waiting CPU lose out.
               if (grant_cpu || !cpu_req) begin
                  starve_d = 4'd0;
               end else if (starve_q != StarveMax) begin
                  starve_d = starve_q + 4'd1;
               end
            end
         end
         StAddr: state_d = StData;
         StData: begin
            state_d = StAck;
            if (owner_q == OwnerCpu) begin
               cpu_data_d = rom_data;
               cpu_ack_d  = 1'b1;
            end else begin
               vid_data_d = rom_data;
               vid_ack_d  = 1'b1;
            end
         end
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         owner_q    <= OwnerVid;
         starve_q   <= 4'd0;
         addr_q     <= '0;
         vid_data_q <= 8'h00;
         cpu_data_q <= 8'h00;
         vid_ack_q  <= 1'b0;
         cpu_ack_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         starve_q   <= starve_d;
         addr_q     <= addr_d;
         vid_data_q <= vid_data_d;
         cpu_data_q <= cpu_data_d;
         vid_ack_q  <= vid_ack_d;
         cpu_ack_q  <= cpu_ack_d;
         busy_q     <= busy_d;
      end
   end

   assign rom_addr = addr_q;
   assign vid_ack  = vid_ack_q;
   assign vid_data = vid_data_q;
   assign cpu_ack  = cpu_ack_q;
   assign cpu_data = cpu_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural 1-cycle ROM (mem[a] = a[7:0] ^ 8'h5A).
module tb_rom_arbiter;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          vid_ack;
   logic [7:0]    vid_data;
   logic          cpu_req = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic          cpu_ack;
   logic [7:0]    cpu_data;
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_data;
   logic          busy;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_vid = 8'h00;
   logic [7:0] exp_cpu = 8'h00;

   rom_arbiter #(.DEPTH(1024), .STARVE_LIMIT(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .vid_req  (vid_req),
      .vid_addr (vid_addr),
      .vid_ack  (vid_ack),
      .vid_data (vid_data),
      .cpu_req  (cpu_req),
      .cpu_addr (cpu_addr),
      .cpu_ack  (cpu_ack),
      .cpu_data (cpu_data),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'h5A;

   task automatic test_reset();
      rst_n = 1'b0; vid_req = 1'b1; cpu_req = 1'b1; vid_addr = 10'h003; cpu_addr = 10'h004;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({vid_ack, cpu_ack, busy} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {vid_ack, cpu_ack, busy});
      end
      checks++;
      if (rom_addr !== 10'h000) begin
         failures++; $display("FAIL reset_rom_addr got=%h exp=000", rom_addr);
      end
      checks++;
      if ({vid_data, cpu_data} !== 16'h0000) begin
         failures++; $display("FAIL reset_data got=%h exp=0000", {vid_data, cpu_data});
      end
      vid_req = 1'b0; cpu_req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            failures++; $display("FAIL idle_busy k=%0d got=%b exp=0", k, busy);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_cpu_single();
      cpu_addr = 10'h010; cpu_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== (k >= 1)) begin
            failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, (k >= 1));
         end
         checks++;
         if ({vid_ack, cpu_ack} !== {1'b0, k == 3}) begin
            failures++;
            $display("FAIL single_ack k=%0d got=%b exp=%b", k, {vid_ack, cpu_ack}, {1'b0, k == 3});
         end
         if (k == 1) begin
            checks++;
            if (rom_addr !== 10'h010) begin
               failures++; $display("FAIL single_rom_addr got=%h exp=010", rom_addr);
            end
         end
         if (k == 3) begin
            exp_cpu = 8'h4A;
            checks++;
            if (cpu_data !== exp_cpu) begin
               failures++; $display("FAIL single_cpu_data got=%h exp=%h", cpu_data, exp_cpu);
            end
            checks++;
            if (vid_data !== exp_vid) begin
               failures++; $display("FAIL single_vid_data got=%h exp=%h", vid_data, exp_vid);
            end
         end
         @(posedge clk); #1;
         if (k == 3) cpu_req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({busy, cpu_ack} !== 2'b00) begin
         failures++; $display("FAIL single_after got=%b exp=00", {busy, cpu_ack});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_both();
      vid_addr = 10'h000; cpu_addr = 10'h3FF; vid_req = 1'b1; cpu_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if ({vid_ack, cpu_ack} !== {k == 3, k == 7}) begin
            failures++;
            $display("FAIL both_ack k=%0d got=%b exp=%b", k, {vid_ack, cpu_ack}, {k == 3, k == 7});
         end
         if (k == 3) begin
            exp_vid = 8'h5A;
            checks++;
            if (vid_data !== exp_vid) begin
               failures++; $display("FAIL both_vid_data got=%h exp=%h", vid_data, exp_vid);
            end
         end
         if (k == 7) begin
            exp_cpu = 8'hA5;
            checks++;
            if ({vid_data, cpu_data} !== {exp_vid, exp_cpu}) begin
               failures++;
               $display("FAIL both_data got=%h exp=%h", {vid_data, cpu_data}, {exp_vid, exp_cpu});
            end
         end
         @(posedge clk); #1;
         if (k == 3) vid_req = 1'b0;
         if (k == 7) cpu_req = 1'b0;
      end
   endtask

   task automatic test_starve();
      vid_addr = 10'h123; cpu_addr = 10'h0F0; vid_req = 1'b1; cpu_req = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if ((k % 4) == 3) begin
            if (((k / 4) % 4) == 3) exp_cpu = 8'hAA;
            else                    exp_vid = 8'h79;
         end
         checks++;
         if ({vid_ack, cpu_ack} !==
             {(k % 4) == 3 && ((k / 4) % 4) != 3, (k % 4) == 3 && ((k / 4) % 4) == 3}) begin
            failures++;
            $display("FAIL starve_ack k=%0d got=%b slot=%0d", k, {vid_ack, cpu_ack}, k / 4);
         end
         checks++;
         if ({vid_data, cpu_data} !== {exp_vid, exp_cpu}) begin
            failures++;
            $display("FAIL starve_data k=%0d got=%h exp=%h", k, {vid_data, cpu_data},
                     {exp_vid, exp_cpu});
         end
         @(posedge clk); #1;
         if (k == 31) begin vid_req = 1'b0; cpu_req = 1'b0; end
      end
   endtask

   task automatic test_starve_clear();
      logic [6:0] pat;
      pat = 7'b1111011;
      vid_addr = 10'h2C3; cpu_addr = 10'h3A5; vid_req = 1'b1;
      for (int k = 0; k < 28; k++) begin
         if ((k % 4) == 0) cpu_req = pat[k / 4];
         @(negedge clk);
         if ((k % 4) == 3) begin
            if ((k / 4) == 6) exp_cpu = 8'hFF;
            else              exp_vid = 8'h99;
         end
         checks++;
         if ({vid_ack, cpu_ack} !== {(k % 4) == 3 && (k / 4) != 6, (k % 4) == 3 && (k / 4) == 6})
         begin
            failures++;
            $display("FAIL clear_ack k=%0d got=%b slot=%0d", k, {vid_ack, cpu_ack}, k / 4);
         end
         checks++;
         if ({vid_data, cpu_data} !== {exp_vid, exp_cpu}) begin
            failures++;
            $display("FAIL clear_data k=%0d got=%h exp=%h", k, {vid_data, cpu_data},
                     {exp_vid, exp_cpu});
         end
         @(posedge clk); #1;
         if (k == 27) begin vid_req = 1'b0; cpu_req = 1'b0; end
      end
   endtask

   task automatic test_reset_mid();
      cpu_addr = 10'h055; cpu_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0; cpu_req = 1'b0;
      exp_vid = 8'h00; exp_cpu = 8'h00;
      #1;
      checks++;
      if ({vid_ack, cpu_ack, busy, rom_addr, vid_data, cpu_data} !== 29'd0) begin
         failures++;
         $display("FAIL midrst_outputs got=%b%b%b %h %h %h exp=all zero", vid_ack, cpu_ack, busy,
                  rom_addr, vid_data, cpu_data);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if ({vid_ack, cpu_ack, busy} !== 3'b000) begin
            failures++; $display("FAIL midrst_quiet k=%0d got=%b exp=000", k,
                                 {vid_ack, cpu_ack, busy});
         end
         @(posedge clk); #1;
      end
      cpu_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (cpu_ack !== (k == 3)) begin
            failures++; $display("FAIL midrst_ack k=%0d got=%b exp=%b", k, cpu_ack, (k == 3));
         end
         if (k == 3) begin
            exp_cpu = 8'h0F;
            checks++;
            if ({vid_data, cpu_data} !== {exp_vid, exp_cpu}) begin
               failures++;
               $display("FAIL midrst_data got=%h exp=%h", {vid_data, cpu_data}, {exp_vid, exp_cpu});
            end
         end
         @(posedge clk); #1;
         if (k == 3) cpu_req = 1'b0;
      end
   endtask

   task automatic test_drop_addr();
      cpu_addr = 10'h0A0; cpu_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if ({vid_ack, cpu_ack} !== {1'b0, k == 3}) begin
            failures++;
            $display("FAIL drop_ack k=%0d got=%b exp=%b", k, {vid_ack, cpu_ack}, {1'b0, k == 3});
         end
         if (k == 1 || k == 2) begin
            checks++;
            if (rom_addr !== 10'h0A0) begin
               failures++; $display("FAIL drop_rom_addr k=%0d got=%h exp=0a0", k, rom_addr);
            end
         end
         if (k == 3) begin
            exp_cpu = 8'hFA;
            checks++;
            if (cpu_data !== exp_cpu) begin
               failures++; $display("FAIL drop_data got=%h exp=%h", cpu_data, exp_cpu);
            end
         end
         @(posedge clk); #1;
         if (k == 0) begin cpu_req = 1'b0; cpu_addr = 10'h1FF; end
      end
   endtask

   initial begin
      test_reset();
      test_cpu_single();
      test_both();
      test_starve();
      test_starve_clear();
      test_reset_mid();
      test_drop_addr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
